// File: rtl/tmds_pkg.sv
// tmds_pkg
// Shared definitions for the TMDS sync extractor: the four DVI control
// tokens, the lock state encoding and the default timing-counter width.
// No ports.
package tmds_pkg;

  localparam int CNT_W_DEFAULT = 12;

  // Control tokens, named by the {C1,C0} value they carry.
  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  typedef enum logic [1:0] {
    LK_SEARCH = 2'd0,
    LK_TRACK  = 2'd1,
    LK_LOCK   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/tmds_ctrl_token_decode.sv
// tmds_ctrl_token_decode
// Classifies one recovered 10-bit TMDS word as control token or data.
// Ports:
//   word    - 10-bit recovered TMDS word
//   is_ctrl - 1 when word is one of the four control tokens
//   c       - {C1,C0} carried by the token (0 for data words)
module tmds_ctrl_token_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       is_ctrl,
  output logic [1:0] c
);

  always_comb begin
    is_ctrl = 1'b1;
    c       = 2'b00;
    case (word)
      TOK_C00: c = 2'b00;
      TOK_C01: c = 2'b01;
      TOK_C10: c = 2'b10;
      TOK_C11: c = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_sync_extractor.sv
// tmds_sync_extractor
// Recovers DE/HSYNC/VSYNC from TMDS control tokens, normalises sync polarity,
// measures frame timing and tracks timing lock.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// LK_SEARCH | no complete frame measured since reset
// LK_TRACK  | reference timing held, counting consecutive matching frames
// LK_LOCK   | LOCK_FRAMES matching frames seen; locked output high
//
// Ports:
//   clk            - TMDS pixel clock (only clock)
//   rst            - synchronous active-low reset
//   tmds_word      - NUM_CH recovered words, channel n at [10n+9:10n]
//   word_valid     - tmds_word qualifier; everything freezes when low
//   vsync, hsync   - active-high sync after polarity normalisation
//   de             - channel-0 word was data
//   vs_pol, hs_pol - detected raw active level (1 = positive sync)
//   h_total, h_active, v_total, v_active - timing of last complete frame
//   locked         - timing stable for LOCK_FRAMES frames
//   ch_err         - one-cycle pulse when a channel's DE disagrees with ch 0
module tmds_sync_extractor
  import tmds_pkg::*;
#(
  parameter int NUM_CH      = 1,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int LOCK_FRAMES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH*10-1:0]  tmds_word,
  input  logic                  word_valid,
  output logic                  vsync,
  output logic                  hsync,
  output logic                  de,
  output logic                  vs_pol,
  output logic                  hs_pol,
  output logic [CNT_W-1:0]      h_total,
  output logic [CNT_W-1:0]      h_active,
  output logic [CNT_W-1:0]      v_total,
  output logic [CNT_W-1:0]      v_active,
  output logic                  locked,
  output logic                  ch_err
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  logic [NUM_CH-1:0]   is_ctrl_ch;
  logic [2*NUM_CH-1:0] c_ch;
  logic                unused_c;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_dec
      tmds_ctrl_token_decode u_dec (
        .word    (tmds_word[10*g +: 10]),
        .is_ctrl (is_ctrl_ch[g]),
        .c       (c_ch[2*g +: 2])
      );
    end
  endgenerate

  // Only channel 0 carries sync; the other channels' C bits are not needed.
  assign unused_c = ^c_ch;

  logic ctrl0;
  logic [1:0] c0;
  assign ctrl0 = is_ctrl_ch[0];
  assign c0    = c_ch[1:0];

  logic mismatch;
  always_comb begin
    mismatch = 1'b0;
    for (int n = 1; n < NUM_CH; n++) begin
      mismatch = mismatch | (is_ctrl_ch[n] ^ is_ctrl_ch[0]);
    end
  end

  // Raw sync follows the last token seen and is held through data.
  logic raw_h, raw_v;
  logic line_has_de, have_frame;
  logic [CNT_W-1:0] pix_cnt, de_cnt, line_len, last_de_len, line_cnt, vde_cnt;
  logic [CNT_W-1:0] match_cnt, ref_h, ref_v;
  lock_state_t      state;

  logic raw_h_nx, raw_v_nx, first_de;
  logic hs_pol_nx, vs_pol_nx, hs_nx, vs_nx;
  logic line_start, frame_start, meas_match;
  logic [CNT_W-1:0] meas_ht, meas_ha, match_inc;

  assign raw_h_nx  = ctrl0 ? c0[0] : raw_h;
  assign raw_v_nx  = ctrl0 ? c0[1] : raw_v;
  // Sync is inactive during active video, so the held level at the first
  // data word of a line is the inactive level.
  assign first_de  = ~ctrl0 & ~line_has_de;
  assign hs_pol_nx = first_de ? ~raw_h : hs_pol;
  assign vs_pol_nx = first_de ? ~raw_v : vs_pol;
  assign hs_nx     = ~(raw_h_nx ^ hs_pol_nx);
  assign vs_nx     = ~(raw_v_nx ^ vs_pol_nx);
  assign line_start  = hs_nx & ~hsync;
  assign frame_start = vs_nx & ~vsync;

  // When the frame start coincides with a line start, pix_cnt is exactly the
  // length of the line that just ended; otherwise use the last stored length.
  assign meas_ht    = line_start ? pix_cnt : line_len;
  assign meas_ha    = line_has_de ? de_cnt : last_de_len;
  assign meas_match = (meas_ht == ref_h) && (line_cnt == ref_v);
  assign match_inc  = sat_inc(match_cnt);

  always_ff @(posedge clk) begin
    if (!rst) begin
      vsync       <= 1'b0;
      hsync       <= 1'b0;
      de          <= 1'b0;
      vs_pol      <= 1'b1;
      hs_pol      <= 1'b1;
      h_total     <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_active    <= '0;
      locked      <= 1'b0;
      ch_err      <= 1'b0;
      raw_h       <= 1'b0;
      raw_v       <= 1'b0;
      line_has_de <= 1'b0;
      have_frame  <= 1'b0;
      pix_cnt     <= '0;
      de_cnt      <= '0;
      line_len    <= '0;
      last_de_len <= '0;
      line_cnt    <= '0;
      vde_cnt     <= '0;
      match_cnt   <= '0;
      ref_h       <= '0;
      ref_v       <= '0;
      state       <= LK_SEARCH;
    end else begin
      ch_err <= 1'b0;
      if (word_valid) begin
        raw_h  <= raw_h_nx;
        raw_v  <= raw_v_nx;
        hs_pol <= hs_pol_nx;
        vs_pol <= vs_pol_nx;
        hsync  <= hs_nx;
        vsync  <= vs_nx;
        de     <= ~ctrl0;
        ch_err <= mismatch;

        if (line_start) begin
          pix_cnt     <= ONE;
          de_cnt      <= '0;
          line_has_de <= 1'b0;
          line_len    <= pix_cnt;
          if (line_has_de) last_de_len <= de_cnt;
          if (!frame_start) line_cnt <= sat_inc(line_cnt);
        end else begin
          pix_cnt <= sat_inc(pix_cnt);
          if (!ctrl0) begin
            de_cnt      <= sat_inc(de_cnt);
            line_has_de <= 1'b1;
            if (!line_has_de) vde_cnt <= sat_inc(vde_cnt);
          end
        end

        if (frame_start) begin
          line_cnt   <= ONE;
          vde_cnt    <= '0;
          have_frame <= 1'b1;
          // The first frame start after reset only opens a frame.
          if (have_frame) begin
            h_total  <= meas_ht;
            h_active <= meas_ha;
            v_total  <= line_cnt;
            v_active <= vde_cnt;
            case (state)
              LK_SEARCH: begin
                // The reference frame itself is the first of the run.
                ref_h     <= meas_ht;
                ref_v     <= line_cnt;
                match_cnt <= ONE;
                if (ONE >= LOCK_N) begin
                  state  <= LK_LOCK;
                  locked <= 1'b1;
                end else begin
                  state  <= LK_TRACK;
                  locked <= 1'b0;
                end
              end
              LK_TRACK, LK_LOCK: begin
                if (meas_match) begin
                  match_cnt <= match_inc;
                  if (match_inc >= LOCK_N) begin
                    state  <= LK_LOCK;
                    locked <= 1'b1;
                  end
                end else begin
                  ref_h     <= meas_ht;
                  ref_v     <= line_cnt;
                  match_cnt <= '0;
                  state     <= LK_TRACK;
                  locked    <= 1'b0;
                end
              end
              default: begin
                state  <= LK_SEARCH;
                locked <= 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tmds_sync_extractor.sv
// tb_tmds_sync_extractor
// Self-checking bench for tmds_sync_extractor (NUM_CH=3, LOCK_FRAMES=3).
module tb_tmds_sync_extractor;

  localparam int NUM_CH = 3;
  localparam int CNT_W = 12;
  localparam int LOCK_FRAMES = 3;
  localparam int H_TOT = 20, H_ACT = 12, H_ACT_START = 4, HS_LEN = 2;
  localparam int V_ACT = 6, V_ACT_START = 3, VS_LEN = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_CH*10-1:0] tmds_word = '0;
  logic word_valid = 1'b0;
  logic vsync, hsync, de, vs_pol, hs_pol, locked, ch_err;
  logic [CNT_W-1:0] h_total, h_active, v_total, v_active;

  always #5 clk = ~clk;

  tmds_sync_extractor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_FRAMES(LOCK_FRAMES)) dut (
    .clk(clk), .rst(rst), .tmds_word(tmds_word), .word_valid(word_valid),
    .vsync(vsync), .hsync(hsync), .de(de), .vs_pol(vs_pol), .hs_pol(hs_pol),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .locked(locked), .ch_err(ch_err)
  );

  typedef struct packed { logic de; logic hs; logic vs; logic ce; } exp_t;
  typedef struct packed { logic [9:0] word; logic de; logic hs; logic vs; logic hpol; logic vpol; } vec_t;

  exp_t exp_q[$];
  exp_t last_exp = '0;
  vec_t tbl[14];
  int n_vec = 0;
  int n_err = 0;
  logic [CNT_W-1:0] snap_ht, snap_ha, snap_vt, snap_va;
  logic snap_locked, snap_hpol, snap_vpol;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [9:0] data_word();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    if (is_token(w)) w = w ^ 10'h001;
    return w;
  endfunction

  function automatic logic [9:0] token(input logic v, input logic h);
    case ({v, h})
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, " de"}, 32'(de), 32'd0);
    check({tag, " hsync"}, 32'(hsync), 32'd0);
    check({tag, " vsync"}, 32'(vsync), 32'd0);
    check({tag, " ch_err"}, 32'(ch_err), 32'd0);
    check({tag, " locked"}, 32'(locked), 32'd0);
    check({tag, " h_total"}, 32'(h_total), 32'd0);
    check({tag, " h_active"}, 32'(h_active), 32'd0);
    check({tag, " v_total"}, 32'(v_total), 32'd0);
    check({tag, " v_active"}, 32'(v_active), 32'd0);
    check({tag, " hs_pol"}, 32'(hs_pol), 32'd1);
    check({tag, " vs_pol"}, 32'(vs_pol), 32'd1);
  endtask

  // Expected output for a driven word is queued before the edge and
  // compared against the DUT just after it.
  task automatic drive_word(input logic [29:0] w, input bit valid, input bit chk, input exp_t e);
    exp_t want, got, held;
    tmds_word  = w;
    word_valid = valid;
    if (chk) begin
      if (valid) begin
        exp_q.push_back(e);
        last_exp = e;
      end else begin
        held = last_exp;
        held.ce = 1'b0;
        exp_q.push_back(held);
      end
    end
    @(posedge clk);
    #1;
    if (chk) begin
      want = exp_q.pop_front();
      got  = {de, hsync, vsync, ch_err};
      check(valid ? "wave {de,hs,vs,ch_err}" : "gap hold {de,hs,vs,ch_err}", 32'(got), 32'(want));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    word_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One frame of 20x10 (or vt lines) timing; sync pulses at the start of
  // line/frame, active area lines 3..8, pixels 4..15.
  task automatic gen_frame(input bit neg, input int vt, input bit chk, input bit gaps,
                           input int rst_line, input int err_line);
    for (int l = 0; l < vt; l++) begin
      for (int p = 0; p < H_TOT; p++) begin
        bit act, hs_a, vs_a, chk_w;
        logic [9:0] w0, w2;
        exp_t e;
        act  = (l >= V_ACT_START) && (l < V_ACT_START + V_ACT) &&
               (p >= H_ACT_START) && (p < H_ACT_START + H_ACT);
        hs_a = (p < HS_LEN);
        vs_a = (l < VS_LEN);
        w0   = act ? data_word() : token(vs_a ^ neg, hs_a ^ neg);
        w2   = w0;
        e    = '{de: act, hs: hs_a, vs: vs_a, ce: 1'b0};
        if (l == err_line && p >= 5 && p < 8) begin
          w2   = data_word();
          e.ce = 1'b1;
        end
        if (gaps) drive_word({data_word(), data_word(), data_word()}, 1'b0, chk, e);
        chk_w = chk;
        if (l == rst_line && p == 8) begin
          rst   = 1'b0;
          chk_w = 1'b0;
        end
        drive_word({w2, w0, w0}, 1'b1, chk_w, e);
        if (!rst) begin
          rst = 1'b1;
          check_reset_vals("midframe reset");
        end
        if (l == 0 && p == 0) begin
          snap_ht = h_total;
          snap_ha = h_active;
          snap_vt = v_total;
          snap_va = v_active;
          snap_locked = locked;
          snap_hpol = hs_pol;
          snap_vpol = vs_pol;
        end
      end
    end
  endtask

  task automatic check_timing(input string tag);
    check({tag, " h_total"}, 32'(snap_ht), 32'd20);
    check({tag, " h_active"}, 32'(snap_ha), 32'd12);
    check({tag, " v_total"}, 32'(snap_vt), 32'd10);
    check({tag, " v_active"}, 32'(snap_va), 32'd6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    //            word     de hs vs hpol vpol
    tbl[0]  = '{10'h354, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{10'h0AB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{10'h154, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{10'h2AB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{10'h354, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{10'h355, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{10'h0AA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{10'h2AB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{10'h354, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{10'h154, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{10'h0AB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{10'h2AA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;

    // Token decode, raw sync hold and polarity latch, with a gap after each word.
    for (int i = 0; i < 14; i++) begin
      drive_word({3{tbl[i].word}}, 1'b1, 1'b0, '0);
      check($sformatf("tbl[%0d] {de,hs,vs,hpol,vpol}", i),
            32'({de, hsync, vsync, hs_pol, vs_pol}),
            32'({tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].hpol, tbl[i].vpol}));
      drive_word({data_word(), 10'h354, 10'h0AB}, 1'b0, 1'b0, '0);
      check($sformatf("tbl[%0d] gap {de,hs,vs,hpol,vpol,ch_err}", i),
            32'({de, hsync, vsync, hs_pol, vs_pol, ch_err}),
            32'({tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].hpol, tbl[i].vpol, 1'b0}));
    end

    // Positive sync: measurement, lock, timing change, channel disagreement.
    do_reset();
    gen_frame(1'b0, 10, 1'b1, 1'b0, -1, -1);
    check("fs1 h_total", 32'(snap_ht), 32'd0);
    check("fs1 v_total", 32'(snap_vt), 32'd0);
    gen_frame(1'b0, 10, 1'b1, 1'b0, -1, 1);
    check_timing("fs2");
    check("fs2 hs_pol", 32'(snap_hpol), 32'd1);
    check("fs2 vs_pol", 32'(snap_vpol), 32'd1);
    check("fs2 locked", 32'(snap_locked), 32'd0);
    gen_frame(1'b0, 10, 1'b1, 1'b0, -1, -1);
    check("fs3 locked", 32'(snap_locked), 32'd0);
    gen_frame(1'b0, 10, 1'b1, 1'b0, -1, -1);
    check("fs4 locked", 32'(snap_locked), 32'd1);
    check_timing("fs4");
    gen_frame(1'b0, 11, 1'b1, 1'b0, -1, -1);
    check("fs5 locked", 32'(snap_locked), 32'd1);
    gen_frame(1'b0, 10, 1'b1, 1'b0, -1, -1);
    check("fs6 locked", 32'(snap_locked), 32'd0);
    check("fs6 v_total", 32'(snap_vt), 32'd11);
    check("fs6 v_active", 32'(snap_va), 32'd6);

    // 50% valid gaps over a whole frame.
    gen_frame(1'b0, 10, 1'b1, 1'b1, -1, -1);
    check("fs7 v_total", 32'(snap_vt), 32'd10);
    gen_frame(1'b0, 10, 1'b1, 1'b1, -1, -1);
    check_timing("gapped fs8");
    check("gapped fs8 locked", 32'(snap_locked), 32'd0);

    // Reset at line 5: partial frame must be discarded.
    gen_frame(1'b0, 10, 1'b1, 1'b0, 5, -1);
    gen_frame(1'b0, 10, 1'b1, 1'b0, -1, -1);
    check("post-reset fs1 v_total", 32'(snap_vt), 32'd0);
    check("post-reset fs1 h_total", 32'(snap_ht), 32'd0);
    gen_frame(1'b0, 10, 1'b1, 1'b0, -1, -1);
    check_timing("post-reset fs2");

    // Negative sync: polarity learned, normalised waveform as positive.
    do_reset();
    gen_frame(1'b1, 10, 1'b0, 1'b0, -1, -1);
    gen_frame(1'b1, 10, 1'b1, 1'b0, -1, -1);
    gen_frame(1'b1, 10, 1'b1, 1'b0, -1, -1);
    check_timing("neg fs3");
    check("neg hs_pol", 32'(snap_hpol), 32'd0);
    check("neg vs_pol", 32'(snap_vpol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tmds_sync_extractor.md
TMDS_SYNC_EXTRACTOR -- requirements
Module: tmds_sync_extractor

Interface
REQ-001 SHALL have parameter NUM_CH, default 1, meaning number of TMDS channels checked (1..3); channel 0 is blue.
REQ-002 SHALL have parameter CNT_W, default 12, meaning width of every timing counter.
REQ-003 SHALL have parameter LOCK_FRAMES, default 3, meaning consecutive identical frames required for lock.
REQ-004 SHALL have port clk, input, 1, meaning TMDS pixel clock; it is the only clock.
REQ-005 SHALL have port rst, input, 1, meaning reset; synchronous, active-low.
REQ-006 SHALL have port tmds_word, input, NUM_CH*10, meaning recovered 10-bit words, channel n at [10n+9:10n].
REQ-007 SHALL have port word_valid, input, 1, meaning tmds_word is qualified this cycle.
REQ-008 SHALL have ports vsync and hsync, output, 1 each, meaning active-high sync after polarity normalisation.
REQ-009 SHALL have port de, output, 1, meaning data enable: channel-0 word is not a control token.
REQ-010 SHALL have ports vs_pol and hs_pol, output, 1 each, meaning detected raw active level (1 = positive sync).
REQ-011 SHALL have ports h_total, h_active, v_total and v_active, output, CNT_W each, meaning measured timing of the last complete frame.
REQ-012 SHALL have port locked, output, 1, meaning timing stable for LOCK_FRAMES frames.
REQ-013 SHALL have port ch_err, output, 1, meaning one-cycle pulse on channel DE disagreement.

Function
REQ-014 SHALL classify a word as a control token only if equal to 0x354 (C=00), 0x0AB (01), 0x154 (10) or 0x2AB (11); any other word is data.
REQ-015 SHALL take channel-0 C0 as raw hsync and C1 as raw vsync, holding the last token values while de is high.
REQ-016 SHALL register all outputs, with one cycle of latency from a valid word to de, vsync and hsync.
REQ-017 SHALL freeze all state, counters and outputs in cycles with word_valid low; ch_err SHALL be low in those cycles.
REQ-018 SHALL, on the first data word of each line, latch vs_pol = ~raw_vsync and hs_pol = ~raw_hsync, because sync is inactive during active video.
REQ-019 SHALL drive vsync = raw_vsync XNOR vs_pol and hsync = raw_hsync XNOR hs_pol.
REQ-020 SHALL define a line start as a normalised hsync rising edge, and a frame start as a normalised vsync rising edge.
REQ-021 SHALL set the internal pixel count to 1 at each line start, and count every valid word in between.
REQ-022 SHALL set the line count to 1 at each frame start.
REQ-023 SHALL count DE words per line and lines containing at least one DE word per frame.
REQ-024 SHALL, at each frame start after the first complete frame, load h_total (last line's pixel count), h_active (DE count of the last line that had DE), v_total and v_active.
REQ-025 SHALL saturate all counters at 2^CNT_W-1 and never wrap.
REQ-026 SHALL use a lock state machine with states SEARCH, TRACK and LOCK:
 - SEARCH -> TRACK on the first complete frame, storing a reference (h_total, v_total).
 - TRACK increments a match count per equal frame and -> LOCK when the count reaches LOCK_FRAMES.
 - In TRACK or LOCK, a mismatching frame -> TRACK with match count 0 and a new reference.
 - locked is high only in LOCK.
REQ-027 SHALL, when NUM_CH>1, pulse ch_err for one cycle whenever any channel's token/data classification differs from channel 0; de SHALL follow channel 0 only.
REQ-028 SHALL give a simultaneous hsync and vsync rising edge both a line start and a frame start, with the frame start taking precedence for the line count.

Reset
REQ-029 SHALL, with rst low at a clk edge, set:
 - vsync, hsync, de, ch_err, locked and all timing outputs to 0;
 - vs_pol and hs_pol to 1;
 - the state machine to SEARCH, with all counters cleared.
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame; the first measurement after release SHALL come from the second frame start.

Structure
REQ-031 SHALL place the four control-token constants, lock state encoding and CNT_W default in shared package tmds_pkg.
REQ-032 SHALL instantiate NUM_CH copies of sub-module tmds_ctrl_token_decode (word -> is_ctrl, c[1:0]).

Verification
REQ-033 SHALL verify nominal timing: positive-sync timing of h_total 20, h_active 12, v_total 10, v_active 6 for 2 frames -> outputs 20/12/10/6 after the second frame start; vs_pol=hs_pol=1.
REQ-034 SHALL verify negative polarity: the same timing with inverted sync tokens -> vs_pol=hs_pol=0; vsync/hsync waveforms identical to the positive case.
REQ-035 SHALL verify lock: 4 identical frames with LOCK_FRAMES=3 -> locked rises at frame start 4; then one frame with v_total 11 -> locked falls at the next frame start.
REQ-036 SHALL verify valid gaps: word_valid toggling 50% over a frame -> identical measurements, with outputs held during gaps.
REQ-037 SHALL verify reset mid-frame: rst low for 1 cycle at line 5 -> all outputs 0 next cycle; first v_total reported equals 10, not a partial value.
REQ-038 SHALL verify channel disagreement: NUM_CH=3 with channel 2 carrying data during channel-0 blanking for 3 cycles -> ch_err high for exactly those 3 cycles; de unaffected.
